riscv_mc_control: RTL and testbench

- Multi-cycle main controller for the single-memory RISC-V core.
- Issues the 5-bit ALU opcodes and all datapath/memory enables, and consumes the ALU's registered result flag (alu_zero).
- Sequences fetch, decode, execute, memory and writeback over a shared instruction/data memory with a ready handshake.
- Counts retired instructions.

---
 rtl/riscv_pkg.sv | 67 ++++++
 rtl/riscv_alu_decoder.sv | 46 ++++
 rtl/riscv_mc_control.sv | 184 ++++++++++++++++++
 tb/tb_riscv_mc_control.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared encodings for the multi-cycle RISC-V controller: ALU opcodes, RV32I opcodes,
// FSM states and datapath mux selects.
package riscv_pkg;

   localparam logic [4:0] ALU_NOP       = 5'd0;
   localparam logic [4:0] ALU_ADD       = 5'd1;
   localparam logic [4:0] ALU_SUB       = 5'd2;
   localparam logic [4:0] ALU_AND       = 5'd3;
   localparam logic [4:0] ALU_OR        = 5'd4;
   localparam logic [4:0] ALU_XOR       = 5'd5;
   localparam logic [4:0] ALU_SLL       = 5'd6;
   localparam logic [4:0] ALU_SRL       = 5'd7;
   localparam logic [4:0] ALU_SRA       = 5'd8;
   localparam logic [4:0] ALU_SLT       = 5'd9;
   localparam logic [4:0] ALU_LUI       = 5'd10;
   localparam logic [4:0] ALU_SLTU      = 5'd11;
   localparam logic [4:0] ALU_BGE       = 5'd12;
   localparam logic [4:0] ALU_BGEU      = 5'd13;
   localparam logic [4:0] ALU_ADDPC     = 5'd14;
   localparam logic [4:0] ALU_JBADDRESS = 5'd15;
   localparam logic [4:0] ALU_BNE       = 5'd16;
   localparam logic [4:0] ALU_BLT       = 5'd17;
   localparam logic [4:0] ALU_BLTU      = 5'd18;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;

   typedef enum logic [3:0] {
      ST_FETCH, ST_DECODE, ST_EXEC, ST_ALU_WB, ST_JUMP, ST_JALR_WB, ST_BR_CHK,
      ST_BR_DONE, ST_MEM_ADDR, ST_MEM_RD, ST_MEM_WR, ST_MEM_WB, ST_HALT
   } state_t;

   localparam logic [1:0] SRCA_PC    = 2'd0;
   localparam logic [1:0] SRCA_RS1   = 2'd1;
   localparam logic [1:0] SRCA_OLDPC = 2'd2;
   localparam logic [1:0] SRCB_RS2   = 2'd0;
   localparam logic [1:0] SRCB_IMM   = 2'd1;

   localparam logic [2:0] IMM_I = 3'd0;
   localparam logic [2:0] IMM_S = 3'd1;
   localparam logic [2:0] IMM_B = 3'd2;
   localparam logic [2:0] IMM_U = 3'd3;
   localparam logic [2:0] IMM_J = 3'd4;

   localparam logic [1:0] WB_ALU = 2'd0;
   localparam logic [1:0] WB_MEM = 2'd1;
   localparam logic [1:0] WB_PC  = 2'd2;

   localparam logic PCSRC_ALU = 1'b0;
   localparam logic PCSRC_TGT = 1'b1;

   function automatic logic is_legal(input logic [6:0] opc);
      case (opc)
         OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR,
         OPC_BRANCH, OPC_LOAD, OPC_STORE: is_legal = 1'b1;
         default:                         is_legal = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/riscv_alu_decoder.sv
// Combinational opcode/funct3/funct7 -> ALU opcode for the execute and branch-compare steps.
module riscv_alu_decoder
   import riscv_pkg::*;
(
   input  logic [6:0] opcode,
   input  logic [2:0] funct3,
   input  logic       funct7_b5,
   output logic [4:0] exec_op,
   output logic [4:0] br_op
);

   always_comb begin
      exec_op = ALU_ADD;
      case (opcode)
         OPC_OP, OPC_OP_IMM: begin
            case (funct3)
               3'b000:  exec_op = (opcode == OPC_OP && funct7_b5) ? ALU_SUB : ALU_ADD;
               3'b001:  exec_op = ALU_SLL;
               3'b010:  exec_op = ALU_SLT;
               3'b011:  exec_op = ALU_SLTU;
               3'b100:  exec_op = ALU_XOR;
               3'b101:  exec_op = funct7_b5 ? ALU_SRA : ALU_SRL;
               3'b110:  exec_op = ALU_OR;
               default: exec_op = ALU_AND;
            endcase
         end
         OPC_LUI: exec_op = ALU_LUI;
         default: exec_op = ALU_ADD;
      endcase
   end

   // Branch taken is signalled by the ALU zero flag, so BGE/BGEU reuse SLT/SLTU.
   always_comb begin
      br_op = ALU_NOP;
      case (funct3)
         3'b000:  br_op = ALU_SUB;
         3'b001:  br_op = ALU_BNE;
         3'b100:  br_op = ALU_BLT;
         3'b101:  br_op = ALU_SLT;
         3'b110:  br_op = ALU_BLTU;
         3'b111:  br_op = ALU_SLTU;
         default: br_op = ALU_NOP;
      endcase
   end

endmodule

// File: rtl/riscv_mc_control.sv
// Multi-cycle main controller: fetch/decode/execute/memory/writeback over one shared memory.
// RISCV_CTRL_TRAP_EN: illegal opcodes halt the core until reset instead of retiring as a NOP.
module riscv_mc_control
   import riscv_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [31:0]      instr,
   input  logic             mem_ready,
   input  logic             alu_zero,
   output logic [4:0]       alu_op,
   output logic [1:0]       src_a_sel,
   output logic [1:0]       src_b_sel,
   output logic [2:0]       imm_sel,
   output logic             ir_write,
   output logic             pc_write,
   output logic             pc_src,
   output logic             tgt_write,
   output logic             mem_read,
   output logic             mem_write,
   output logic             addr_sel,
   output logic             reg_write,
   output logic [1:0]       wb_sel,
   output logic             illegal,
   output logic [CNT_W-1:0] retired
);

   state_t     state;
   logic [6:0] opcode;
   logic [4:0] exec_op;
   logic [4:0] br_op;
   logic       legal;
   logic       unused_bits;

   assign opcode      = instr[6:0];
   assign legal       = is_legal(opcode);
   assign unused_bits = ^{instr[31], instr[29:15], instr[11:7]};

   riscv_alu_decoder u_alu_dec (
      .opcode    (opcode),
      .funct3    (instr[14:12]),
      .funct7_b5 (instr[30]),
      .exec_op   (exec_op),
      .br_op     (br_op)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= ST_FETCH;
         retired <= '0;
      end else begin
         case (state)
            ST_FETCH:    if (mem_ready) state <= ST_DECODE;
            ST_DECODE: begin
               case (opcode)
                  OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC, OPC_JALR: state <= ST_EXEC;
                  OPC_LOAD, OPC_STORE: state <= ST_MEM_ADDR;
                  OPC_BRANCH:          state <= ST_BR_CHK;
                  OPC_JAL:             state <= ST_JUMP;
                  default: begin
`ifdef RISCV_CTRL_TRAP_EN
                     state   <= ST_HALT;
`else
                     state   <= ST_FETCH;
                     retired <= retired + CNT_W'(1);
`endif
                  end
               endcase
            end
            ST_EXEC:     state <= (opcode == OPC_JALR) ? ST_JALR_WB : ST_ALU_WB;
            ST_BR_CHK:   state <= ST_BR_DONE;
            ST_MEM_ADDR: state <= (opcode == OPC_STORE) ? ST_MEM_WR : ST_MEM_RD;
            ST_MEM_RD:   if (mem_ready) state <= ST_MEM_WB;
            ST_MEM_WR: begin
               if (mem_ready) begin
                  state   <= ST_FETCH;
                  retired <= retired + CNT_W'(1);
               end
            end
            ST_ALU_WB, ST_JUMP, ST_JALR_WB, ST_BR_DONE, ST_MEM_WB: begin
               state   <= ST_FETCH;
               retired <= retired + CNT_W'(1);
            end
            ST_HALT:     state <= ST_HALT;
            default:     state <= ST_FETCH;
         endcase
      end
   end

   // Outputs are forced idle while reset is high so an in-flight access drops at once.
   always_comb begin
      alu_op    = ALU_NOP;
      src_a_sel = SRCA_PC;
      src_b_sel = SRCB_RS2;
      imm_sel   = IMM_I;
      ir_write  = 1'b0;
      pc_write  = 1'b0;
      pc_src    = PCSRC_ALU;
      tgt_write = 1'b0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      addr_sel  = 1'b0;
      reg_write = 1'b0;
      wb_sel    = WB_ALU;
      illegal   = 1'b0;
      if (!reset) begin
         case (state)
            ST_FETCH: begin
               mem_read = 1'b1;
               if (mem_ready) begin
                  ir_write = 1'b1;
                  alu_op   = ALU_ADDPC;
               end
            end
            ST_DECODE: begin
               pc_write  = 1'b1;
               alu_op    = ALU_ADD;
               src_a_sel = SRCA_OLDPC;
               src_b_sel = SRCB_IMM;
               if (opcode == OPC_BRANCH)   imm_sel = IMM_B;
               else if (opcode == OPC_JAL) imm_sel = IMM_J;
               illegal   = !legal;
            end
            ST_EXEC: begin
               alu_op = exec_op;
               case (opcode)
                  OPC_OP:     src_a_sel = SRCA_RS1;
                  OPC_OP_IMM, OPC_JALR: begin
                     src_a_sel = SRCA_RS1;
                     src_b_sel = SRCB_IMM;
                  end
                  OPC_LUI: begin
                     src_b_sel = SRCB_IMM;
                     imm_sel   = IMM_U;
                  end
                  OPC_AUIPC: begin
                     src_a_sel = SRCA_OLDPC;
                     src_b_sel = SRCB_IMM;
                     imm_sel   = IMM_U;
                  end
                  default: src_a_sel = SRCA_RS1;
               endcase
            end
            ST_ALU_WB: begin
               reg_write = 1'b1;
               wb_sel    = WB_ALU;
            end
            ST_JUMP, ST_JALR_WB: begin
               pc_write  = 1'b1;
               reg_write = 1'b1;
               wb_sel    = WB_PC;
            end
            ST_BR_CHK: begin
               tgt_write = 1'b1;
               alu_op    = br_op;
               src_a_sel = SRCA_RS1;
               src_b_sel = SRCB_RS2;
            end
            ST_BR_DONE: begin
               pc_write = alu_zero;
               pc_src   = PCSRC_TGT;
            end
            ST_MEM_ADDR, ST_MEM_RD, ST_MEM_WR: begin
               alu_op    = ALU_ADD;
               src_a_sel = SRCA_RS1;
               src_b_sel = SRCB_IMM;
               imm_sel   = (opcode == OPC_STORE) ? IMM_S : IMM_I;
               addr_sel  = (state != ST_MEM_ADDR);
               mem_read  = (state == ST_MEM_RD);
               mem_write = (state == ST_MEM_WR);
            end
            ST_MEM_WB: begin
               reg_write = 1'b1;
               wb_sel    = WB_MEM;
            end
            ST_HALT:  illegal = 1'b1;
            default:  illegal = 1'b0;
         endcase
      end
   end

endmodule

// File: tb/tb_riscv_mc_control.sv
// Directed bench for riscv_mc_control; checks the control outputs state by state.
module tb_riscv_mc_control;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] instr;
   logic        mem_ready;
   logic        alu_zero;
   logic [4:0]  alu_op;
   logic [1:0]  src_a_sel;
   logic [1:0]  src_b_sel;
   logic [2:0]  imm_sel;
   logic        ir_write;
   logic        pc_write;
   logic        pc_src;
   logic        tgt_write;
   logic        mem_read;
   logic        mem_write;
   logic        addr_sel;
   logic        reg_write;
   logic [1:0]  wb_sel;
   logic        illegal;
   logic [31:0] retired;

   int tests = 0;
   int fails = 0;

   riscv_mc_control #(.CNT_W(32)) dut (
      .clk       (clk),
      .reset     (reset),
      .instr     (instr),
      .mem_ready (mem_ready),
      .alu_zero  (alu_zero),
      .alu_op    (alu_op),
      .src_a_sel (src_a_sel),
      .src_b_sel (src_b_sel),
      .imm_sel   (imm_sel),
      .ir_write  (ir_write),
      .pc_write  (pc_write),
      .pc_src    (pc_src),
      .tgt_write (tgt_write),
      .mem_read  (mem_read),
      .mem_write (mem_write),
      .addr_sel  (addr_sel),
      .reg_write (reg_write),
      .wb_sel    (wb_sel),
      .illegal   (illegal),
      .retired   (retired)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Fetch completes in its first cycle; leaves the FSM in DECODE.
   task automatic fetch(input logic [31:0] i);
      instr     = i;
      mem_ready = 1'b1;
      #1;
      check("fetch_mem_read", 32'(mem_read), 1);
      check("fetch_ir_write", 32'(ir_write), 1);
      check("fetch_alu_op",   32'(alu_op), 14);
      tick();
      mem_ready = 1'b0;
      #1;
      check("decode_pc_write", 32'(pc_write), 1);
   endtask

   initial begin
      reset     = 1'b1;
      instr     = 32'h0;
      mem_ready = 1'b0;
      alu_zero  = 1'b0;
      #12;
      check("rst_mem_read", 32'(mem_read), 0);
      check("rst_alu_op",   32'(alu_op), 0);
      check("rst_retired",  retired, 0);
      check("rst_illegal",  32'(illegal), 0);
      reset = 1'b0;
      #1;
      check("fetch_wait_rd", 32'(mem_read), 1);
      check("fetch_wait_ir", 32'(ir_write), 0);
      tick();

      // ADD x3,x1,x2
      fetch(32'h002081B3);
      check("add_dec_alu", 32'(alu_op), 1);
      check("add_dec_srca", 32'(src_a_sel), 2);
      check("add_dec_srcb", 32'(src_b_sel), 1);
      tick();
      check("add_exec_alu", 32'(alu_op), 1);
      check("add_exec_srcb", 32'(src_b_sel), 0);
      check("add_exec_srca", 32'(src_a_sel), 1);
      tick();
      check("add_wb_regw", 32'(reg_write), 1);
      check("add_wb_sel", 32'(wb_sel), 0);
      tick();
      check("add_retired", retired, 1);
      check("add_back_fetch", 32'(mem_read), 1);

      // SUB
      fetch(32'h402081B3);
      tick();
      check("sub_exec_alu", 32'(alu_op), 2);
      tick(); tick();

      // SRAI
      fetch(32'h4020D193);
      tick();
      check("srai_exec_alu", 32'(alu_op), 8);
      check("srai_exec_srcb", 32'(src_b_sel), 1);
      tick(); tick();
      check("srai_retired", retired, 3);

      // BEQ taken
      fetch(32'h00208463);
      check("beq_dec_imm", 32'(imm_sel), 2);
      tick();
      check("beq_chk_alu", 32'(alu_op), 2);
      check("beq_chk_tgt", 32'(tgt_write), 1);
      check("beq_chk_srca", 32'(src_a_sel), 1);
      alu_zero = 1'b1;
      tick();
      check("beq_t_pcw", 32'(pc_write), 1);
      check("beq_t_pcsrc", 32'(pc_src), 1);
      tick();
      alu_zero = 1'b0;

      // BEQ not taken
      fetch(32'h00208463);
      tick(); tick();
      check("beq_nt_pcw", 32'(pc_write), 0);
      tick();

      // BGE
      fetch(32'h0020D463);
      tick();
      check("bge_chk_alu", 32'(alu_op), 9);
      tick(); tick();
      check("br_retired", retired, 6);

      // LW with a 3-cycle memory stall
      fetch(32'h0000A183);
      tick();
      check("lw_addr_alu", 32'(alu_op), 1);
      check("lw_addr_rd", 32'(mem_read), 0);
      tick();
      for (int k = 0; k < 4; k++) begin
         mem_ready = (k == 3);
         #1;
         check("lw_rd_mem_read", 32'(mem_read), 1);
         check("lw_rd_addr_sel", 32'(addr_sel), 1);
         check("lw_rd_alu", 32'(alu_op), 1);
         tick();
      end
      mem_ready = 1'b0;
      #1;
      check("lw_wb_regw", 32'(reg_write), 1);
      check("lw_wb_sel", 32'(wb_sel), 1);
      tick();
      check("lw_retired", retired, 7);

      // JAL
      fetch(32'h008000EF);
      check("jal_dec_imm", 32'(imm_sel), 4);
      tick();
      check("jal_pcw", 32'(pc_write), 1);
      check("jal_regw", 32'(reg_write), 1);
      check("jal_wbsel", 32'(wb_sel), 2);
      tick();
      check("jal_retired", retired, 8);

      // Illegal opcode
      fetch(32'h00000000);
      check("ill_dec_flag", 32'(illegal), 1);
      tick();
`ifdef RISCV_CTRL_TRAP_EN
      tick(); tick();
      check("ill_halt_flag", 32'(illegal), 1);
      check("ill_halt_rd", 32'(mem_read), 0);
      check("ill_halt_ret", retired, 8);
`else
      check("ill_nop_flag", 32'(illegal), 0);
      check("ill_nop_fetch", 32'(mem_read), 1);
      check("ill_nop_ret", retired, 9);
`endif

      // Reset in the middle of a store
      reset = 1'b1;
      tick();
      reset = 1'b0;
      #1;
      fetch(32'h0020A023);
      tick();
      check("sw_addr_imm", 32'(imm_sel), 1);
      tick();
      check("sw_wr_mem_write", 32'(mem_write), 1);
      check("sw_wr_addr_sel", 32'(addr_sel), 1);
      #2;
      reset = 1'b1;
      #1;
      check("sw_rst_mem_write", 32'(mem_write), 0);
      check("sw_rst_ret", retired, 0);
      tick();
      reset = 1'b0;
      #1;
      check("sw_post_fetch", 32'(mem_read), 1);
      check("sw_post_wr", 32'(mem_write), 0);
      check("sw_post_ret", retired, 0);
      check("sw_post_regw", 32'(reg_write), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
